sparse_job_sequencer: RTL and testbench
=======================================

SPARSE_JOB_SEQUENCER -- requirements
Module: sparse_job_sequencer

Interface
REQ-001 SHALL have parameter CORE_LAT, default 2, meaning core_en-high cycles before core_psum is valid; legal range 1..15.
REQ-002 SHALL have parameter TILE_W, default 8, meaning width of the tile count and tile index.
REQ-003 SHALL have port aclk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port aresetn, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port start, input, 1 bit: job start request; sampled only in IDLE.
REQ-006 SHALL have port abort, input, 1 bit: cancels the current job.
REQ-007 SHALL have port tile_count, input, TILE_W bits: number of tiles in the job; sampled with start.
REQ-008 SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-009 SHALL have port done, output, 1 bit: one-cycle pulse marking job completion.
REQ-010 SHALL have port wmem_rd, output, 1 bit: weight memory read strobe.
REQ-011 SHALL have port wmem_addr, output, TILE_W+3 bits: weight memory address.
REQ-012 SHALL have port wmem_rdata, input, 10 bits: weight entry {idx[1:0], val[7:0]}, valid exactly 1 cycle after wmem_rd.
REQ-013 SHALL have port act_valid, input, 1 bit: activation vector offered.
REQ-014 SHALL have port act_ready, output, 1 bit: activation vector accepted.
REQ-015 SHALL have port act_data, input, 32 bits: four 8-bit activations, lane i in bits [8i+7:8i].
REQ-016 SHALL have port core_en, output, 1 bit: sparse core enable.
REQ-017 SHALL have port core_w_val, output, 64 bits: eight weight values, entry k in bits [8k+7:8k]; row r uses entries 2r and 2r+1.
REQ-018 SHALL have port core_w_idx, output, 16 bits: eight 2-bit indices, entry k in bits [2k+1:2k].
REQ-019 SHALL have port core_act, output, 32 bits: latched activation vector.
REQ-020 SHALL have port core_psum, input, 80 bits: four signed 20-bit partial sums, lane i in bits [20i+19:20i].
REQ-021 SHALL have port res_valid, output, 1 bit: result offered.
REQ-022 SHALL have port res_ready, input, 1 bit: result accepted.
REQ-023 SHALL have port res_data, output, 128 bits: four signed 32-bit results, lane i in bits [32i+31:32i].
REQ-024 SHALL have port res_tile, output, TILE_W bits: index of the tile the result belongs to.

Function
REQ-025 SHALL implement states IDLE, LOAD, WAIT_ACT, COMPUTE, OUTPUT.
REQ-026 SHALL, in IDLE with start=1 and tile_count>0, latch tile_count, clear the tile index to 0 and enter LOAD.
REQ-027 SHALL, in IDLE with start=1 and tile_count=0, pulse done on the next cycle, issue no reads and stay in IDLE.
REQ-028 SHALL, in LOAD, assert wmem_rd for exactly 8 consecutive cycles with wmem_addr = tile*8+k, k=0..7.
REQ-029 SHALL capture each wmem_rdata one cycle after its read into entry k, so LOAD lasts 9 cycles, then enter WAIT_ACT.
REQ-030 SHALL hold act_ready=1 only in WAIT_ACT; on act_valid&&act_ready, latch act_data into core_act and enter COMPUTE.
REQ-031 SHALL hold core_en=1 for exactly CORE_LAT cycles in COMPUTE.
REQ-032 SHALL, on the last COMPUTE cycle, capture core_psum sign-extended to 32 bits per lane into res_data, set res_tile to the current tile, and enter OUTPUT.
REQ-033 SHALL hold res_valid=1 in OUTPUT, with res_data and res_tile stable, until res_ready=1.
REQ-034 SHALL, on the OUTPUT handshake, pulse done and enter IDLE if tile = count-1; otherwise increment tile and enter LOAD.
REQ-035 SHALL hold core_w_val, core_w_idx and core_act stable from LOAD exit through COMPUTE.
REQ-036 SHALL, when abort=1 in any non-IDLE state, enter IDLE next cycle with no done pulse, and deassert res_valid, core_en and wmem_rd; abort has priority over all other events.
REQ-037 SHALL ignore start while busy.

Reset
REQ-038 SHALL, while aresetn=0, force state IDLE and hold busy, done, wmem_rd, act_ready, core_en and res_valid at 0.
REQ-039 SHALL, while aresetn=0, hold wmem_addr, core_w_val, core_w_idx, core_act, res_data and res_tile at 0.
REQ-040 SHALL, when reset is asserted mid-job, discard the job; after release the block waits for a new start.

Verification
REQ-041 SHALL cover a single tile: memory entry k = {k[1:0], 8'h10+k}, act_data=32'h04030201, psum lanes = {-5, 7, 0, 524287} -> 8 reads at addresses 0..7, then core_en high for 2 cycles, then res_data lanes = {FFFFFFFB, 00000007, 0, 0007FFFF}, res_tile=0, done pulsed once.
REQ-042 SHALL cover tile_count=3 with res_ready held low for 5 cycles on tile 1 -> read addresses 0..23, res_data stable while stalled, res_tile 0,1,2, a single done pulse.
REQ-043 SHALL cover tile_count=0 -> done pulsed 1 cycle after start, no wmem_rd, busy never set.
REQ-044 SHALL cover abort asserted during cycle 4 of COMPUTE with CORE_LAT=8 -> IDLE next cycle, core_en=0, no res_valid, no done.
REQ-045 SHALL cover aresetn pulled low during OUTPUT -> res_valid and busy drop to 0 immediately; after release, a new start runs a clean job from tile 0.
REQ-046 SHALL cover start pulsed while busy, with act_valid held low for 10 cycles in WAIT_ACT -> the second start is ignored and the job resumes correctly when act_valid rises.

Source files
------------

// File: rtl/sparse_job_sequencer.sv
// Sparse job sequencer: steps a multi-tile job through weight load,
// activation fetch, sparse-core compute and a result handshake.
module sparse_job_sequencer #(
  parameter int CORE_LAT = 2,
  parameter int TILE_W   = 8
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              start,
  input  logic              abort,
  input  logic [TILE_W-1:0] tile_count,
  output logic              busy,
  output logic              done,
  output logic              wmem_rd,
  output logic [TILE_W+2:0] wmem_addr,
  input  logic [9:0]        wmem_rdata,
  input  logic              act_valid,
  output logic              act_ready,
  input  logic [31:0]       act_data,
  output logic              core_en,
  output logic [63:0]       core_w_val,
  output logic [15:0]       core_w_idx,
  output logic [31:0]       core_act,
  input  logic [79:0]       core_psum,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [127:0]      res_data,
  output logic [TILE_W-1:0] res_tile
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT_ACT,
    S_COMPUTE,
    S_OUTPUT
  } state_e;

  localparam logic [3:0] LAT_LAST = 4'(CORE_LAT - 1);

  state_e              state_q, state_d;
  logic [TILE_W-1:0]   tile_q, count_q;
  logic [3:0]          k_q;        // LOAD cycle: 0..7 issue reads, 1..8 capture
  logic [3:0]          lat_q;      // COMPUTE cycle counter
  logic [7:0]          w_val_q [8];
  logic [1:0]          w_idx_q [8];
  logic [31:0]         act_q;
  logic [127:0]        res_data_q;
  logic [TILE_W-1:0]   res_tile_q;
  logic                done_q;
  logic                last_tile;

  assign last_tile = (tile_q == count_q - TILE_W'(1));

  // State register.
  // NOTE: every clocked process uses non-blocking assignments so all
  // registers update from the same pre-edge values.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next-state decode and state-derived strobes; abort wins over everything.
  // NOTE: every output of this block gets a default first so no latch is
  // inferred on paths that do not assign it.
  always_comb begin
    state_d   = state_q;
    busy      = (state_q != S_IDLE);
    wmem_rd   = 1'b0;
    wmem_addr = '0;
    act_ready = (state_q == S_WAIT_ACT);
    core_en   = (state_q == S_COMPUTE);
    res_valid = (state_q == S_OUTPUT);
    if (state_q == S_LOAD && k_q < 4'd8) begin
      wmem_rd   = 1'b1;
      wmem_addr = {tile_q, k_q[2:0]};
    end
    if (abort && state_q != S_IDLE) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE:     if (start && tile_count != '0) state_d = S_LOAD;
        S_LOAD:     if (k_q == 4'd8)               state_d = S_WAIT_ACT;
        S_WAIT_ACT: if (act_valid)                 state_d = S_COMPUTE;
        S_COMPUTE:  if (lat_q == LAT_LAST)         state_d = S_OUTPUT;
        S_OUTPUT:   if (res_ready)                 state_d = last_tile ? S_IDLE : S_LOAD;
        default:                                   state_d = S_IDLE;
      endcase
    end
  end

  // Job bookkeeping, weight/activation capture and result capture.
  // NOTE: the weight table is reset along with the other registers because
  // it drives core outputs that must read zero during reset.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      tile_q     <= '0;
      count_q    <= '0;
      k_q        <= '0;
      lat_q      <= '0;
      act_q      <= '0;
      res_data_q <= '0;
      res_tile_q <= '0;
      done_q     <= 1'b0;
      for (int k = 0; k < 8; k++) begin
        w_val_q[k] <= '0;
        w_idx_q[k] <= '0;
      end
    end else begin
      done_q <= 1'b0;
      k_q    <= (state_q == S_LOAD && state_d == S_LOAD) ? k_q + 4'd1 : '0;
      lat_q  <= (state_q == S_COMPUTE && state_d == S_COMPUTE) ? lat_q + 4'd1 : '0;

      if (state_q == S_IDLE && start) begin
        if (tile_count == '0) begin
          done_q <= 1'b1;
        end else begin
          count_q <= tile_count;
          tile_q  <= '0;
        end
      end

      if (!abort) begin
        // Read data for entry k-1 arrives one cycle after its strobe.
        if (state_q == S_LOAD && k_q != 4'd0) begin
          w_val_q[3'(k_q - 4'd1)] <= wmem_rdata[7:0];
          w_idx_q[3'(k_q - 4'd1)] <= wmem_rdata[9:8];
        end
        if (state_q == S_WAIT_ACT && act_valid) act_q <= act_data;
        if (state_q == S_COMPUTE && lat_q == LAT_LAST) begin
          for (int i = 0; i < 4; i++) begin
            res_data_q[32*i +: 32] <= {{12{core_psum[20*i+19]}}, core_psum[20*i +: 20]};
          end
          res_tile_q <= tile_q;
        end
        if (state_q == S_OUTPUT && res_ready) begin
          if (last_tile) done_q <= 1'b1;
          else           tile_q <= tile_q + TILE_W'(1);
        end
      end
    end
  end

  // Flatten the weight table onto the core buses.
  always_comb begin
    core_w_val = '0;
    core_w_idx = '0;
    for (int k = 0; k < 8; k++) begin
      core_w_val[8*k +: 8] = w_val_q[k];
      core_w_idx[2*k +: 2] = w_idx_q[k];
    end
  end

  assign core_act = act_q;
  assign res_data = res_data_q;
  assign res_tile = res_tile_q;
  assign done     = done_q;

endmodule

// File: tb/tb_sparse_job_sequencer.sv
// Self-checking bench for sparse_job_sequencer: a job-level model predicts
// read addresses, weights, activations and results; a compare process
// checks the DUT against it every cycle.
module tb_sparse_job_sequencer;

  localparam int LAT = 2;

  logic         aclk = 1'b0, aresetn = 1'b0;
  logic         start = 1'b0, abort = 1'b0;
  logic [7:0]   tile_count = '0;
  logic         busy, done, wmem_rd, act_ready, core_en, res_valid;
  logic [10:0]  wmem_addr;
  logic [9:0]   wmem_rdata = '0;
  logic         act_valid = 1'b0, res_ready = 1'b0;
  logic [31:0]  act_data = '0;
  logic [63:0]  core_w_val;
  logic [15:0]  core_w_idx;
  logic [31:0]  core_act;
  logic [79:0]  core_psum = '0;
  logic [127:0] res_data;
  logic [7:0]   res_tile;

  // Second instance with a long core latency for the abort scenario.
  logic         start8 = 1'b0, abort8 = 1'b0, act_valid8 = 1'b1, res_ready8 = 1'b1;
  logic [7:0]   tile_count8 = 8'd1;
  logic [9:0]   wmem_rdata8 = '0;
  logic [31:0]  act_data8 = 32'h11223344;
  logic [79:0]  core_psum8 = '0;
  logic         busy8, done8, wmem_rd8, act_ready8, core_en8, res_valid8;
  logic [10:0]  wmem_addr8;
  logic [63:0]  core_w_val8;
  logic [15:0]  core_w_idx8;
  logic [31:0]  core_act8;
  logic [127:0] res_data8;
  logic [7:0]   res_tile8;

  sparse_job_sequencer #(.CORE_LAT(LAT), .TILE_W(8)) u_dut (
    .aclk(aclk), .aresetn(aresetn), .start(start), .abort(abort),
    .tile_count(tile_count), .busy(busy), .done(done), .wmem_rd(wmem_rd),
    .wmem_addr(wmem_addr), .wmem_rdata(wmem_rdata), .act_valid(act_valid),
    .act_ready(act_ready), .act_data(act_data), .core_en(core_en),
    .core_w_val(core_w_val), .core_w_idx(core_w_idx), .core_act(core_act),
    .core_psum(core_psum), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_tile(res_tile)
  );

  sparse_job_sequencer #(.CORE_LAT(8), .TILE_W(8)) u_dut8 (
    .aclk(aclk), .aresetn(aresetn), .start(start8), .abort(abort8),
    .tile_count(tile_count8), .busy(busy8), .done(done8), .wmem_rd(wmem_rd8),
    .wmem_addr(wmem_addr8), .wmem_rdata(wmem_rdata8), .act_valid(act_valid8),
    .act_ready(act_ready8), .act_data(act_data8), .core_en(core_en8),
    .core_w_val(core_w_val8), .core_w_idx(core_w_idx8), .core_act(core_act8),
    .core_psum(core_psum8), .res_valid(res_valid8), .res_ready(res_ready8),
    .res_data(res_data8), .res_tile(res_tile8)
  );

  always #5 aclk = ~aclk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic logic [9:0] mem_at(input int a);
    logic [7:0] v;
    v = 8'h10 + 8'(a);
    return {a[1:0], v};
  endfunction

  function automatic logic [31:0] act_for(input int t);
    return (t == 0) ? 32'h04030201 : (32'hC0DE0000 | 32'(t));
  endfunction

  function automatic logic [79:0] psum_for(input int t);
    if (t == 0) return {20'h7FFFF, 20'h00000, 20'h00007, 20'hFFFFB};
    return {20'(t * 3), 20'hFFFFF - 20'(t), 20'h80000, 20'(t)};
  endfunction

  function automatic logic [127:0] exp_res(input int t);
    logic [79:0]        p;
    logic signed [19:0] s;
    int                 v;
    logic [127:0]       r;
    p = psum_for(t);
    for (int i = 0; i < 4; i++) begin
      s = p[20*i +: 20];
      v = s;
      r[32*i +: 32] = v;
    end
    return r;
  endfunction

  function automatic logic [63:0] exp_wval(input int t);
    logic [63:0] w;
    logic [9:0]  m;
    for (int k = 0; k < 8; k++) begin
      m = mem_at(t * 8 + k);
      w[8*k +: 8] = m[7:0];
    end
    return w;
  endfunction

  function automatic logic [15:0] exp_widx(input int t);
    logic [15:0] w;
    logic [9:0]  m;
    for (int k = 0; k < 8; k++) begin
      m = mem_at(t * 8 + k);
      w[2*k +: 2] = m[9:8];
    end
    return w;
  endfunction

  int exp_addr[$];
  int exp_tile[$];
  int tile_seen = 0;
  int done_cnt  = 0;
  int en_cnt    = 0;
  logic [127:0] last_res;
  logic [63:0]  last_wval;
  logic [15:0]  last_widx;
  logic [31:0]  last_act;

  task automatic expect_job(input int n);
    for (int t = 0; t < n; t++) begin
      for (int k = 0; k < 8; k++) exp_addr.push_back(t * 8 + k);
      exp_tile.push_back(t);
    end
    tile_seen = 0;
  endtask

  // Weight memory: data for a read appears during the following cycle.
  always begin : mem_resp
    logic        p;
    logic [10:0] a;
    @(negedge aclk);
    p = wmem_rd;
    a = wmem_addr;
    @(posedge aclk);
    #1;
    wmem_rdata = p ? mem_at(int'(a)) : 10'h2A5;
  end

  // Sparse core: psum is only valid in the LAT-th consecutive enable cycle.
  int run_len = 0;
  always @(negedge aclk) begin
    if (core_en) run_len++;
    else         run_len = 0;
    core_psum = (core_en && run_len == LAT) ? psum_for(tile_seen) : 80'h5A5A5_A5A5A_5A5A5_A5A5A;
  end

  // Compare process.
  always @(negedge aclk) begin : cmp
    int t;
    if (aresetn) begin
      if (wmem_rd) begin
        if (exp_addr.size() == 0) check("wmem_rd spurious", wmem_rd, 1'b0);
        else                      check("wmem_addr", wmem_addr, 128'(exp_addr.pop_front()));
      end
      if (core_en) begin
        en_cnt++;
        last_wval = core_w_val;
        last_widx = core_w_idx;
        last_act  = core_act;
        if (exp_tile.size() == 0) check("core_en spurious", core_en, 1'b0);
        else begin
          t = exp_tile[0];
          check("core_w_val", core_w_val, exp_wval(t));
          check("core_w_idx", core_w_idx, exp_widx(t));
          check("core_act", core_act, act_for(t));
        end
      end
      if (res_valid) begin
        if (exp_tile.size() == 0) check("res_valid spurious", res_valid, 1'b0);
        else begin
          t = exp_tile[0];
          check("res_data", res_data, exp_res(t));
          check("res_tile", res_tile, 128'(t));
          if (res_ready) begin
            last_res = res_data;
            void'(exp_tile.pop_front());
            tile_seen++;
          end
        end
      end
      if (done) done_cnt++;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic do_start(input int n);
    tile_count = 8'(n);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_act(input int t, input int delay, input bit poke);
    int cyc = 0;
    while (!act_ready && cyc < 200) begin tick(); cyc++; end
    check("act_ready reached", act_ready, 1'b1);
    for (int d = 0; d < delay; d++) begin
      if (poke && d == 2) begin start = 1'b1; tile_count = 8'd5; end
      tick();
      start = 1'b0;
    end
    check("act_ready held", act_ready, 1'b1);
    act_valid = 1'b1;
    act_data  = act_for(t);
    tick();
    act_valid = 1'b0;
    act_data  = '1;
    check("act_ready after handshake", act_ready, 1'b0);
  endtask

  task automatic wait_res();
    int cyc = 0;
    while (!res_valid && cyc < 200) begin tick(); cyc++; end
    check("res_valid reached", res_valid, 1'b1);
  endtask

  task automatic serve_job(input int n, input int stall_tile, input int stall_n,
                           input int act_delay, input bit poke);
    for (int t = 0; t < n; t++) begin
      send_act(t, (t == 0) ? act_delay : 0, poke && t == 0);
      wait_res();
      if (t == stall_tile) begin
        repeat (stall_n) tick();
        check("res_valid held in stall", res_valid, 1'b1);
      end
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      if (t == n - 1) begin
        check("done after last", done, 1'b1);
        check("busy after last", busy, 1'b0);
      end else begin
        check("no done mid-job", done, 1'b0);
        check("busy mid-job", busy, 1'b1);
      end
    end
  endtask

  task automatic run_job(input string name, input int n, input int stall_tile,
                         input int stall_n, input int act_delay, input bit poke);
    int d0, e0;
    d0 = done_cnt;
    e0 = en_cnt;
    expect_job(n);
    do_start(n);
    serve_job(n, stall_tile, stall_n, act_delay, poke);
    repeat (4) tick();
    check({name, " done count"}, 128'(done_cnt - d0), 128'd1);
    check({name, " core_en cycles"}, 128'(en_cnt - e0), 128'(LAT * n));
    check({name, " reads consumed"}, 128'(exp_addr.size()), 128'd0);
    check({name, " results consumed"}, 128'(exp_tile.size()), 128'd0);
    check({name, " idle after"}, busy, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, n_rv, n_dn, cyc;

    // Reset values.
    #12;
    check("reset strobes", {busy, done, wmem_rd, act_ready, core_en, res_valid}, 6'b0);
    check("reset wmem_addr", wmem_addr, 0);
    check("reset core buses", {core_w_val, core_w_idx, core_act}, 0);
    check("reset result", {res_data, res_tile}, 0);
    tick();
    aresetn = 1'b1;
    tick();

    // Single tile with pinned literal expectations.
    run_job("single", 1, -1, 0, 0, 1'b0);
    check("T1 res_data literal", last_res, 128'h0007FFFF_00000000_00000007_FFFFFFFB);
    check("T1 w_val literal", last_wval, 64'h17161514_13121110);
    check("T1 w_idx literal", last_widx, 16'hE4E4);
    check("T1 act literal", last_act, 32'h04030201);

    // Three tiles with a 5-cycle result stall on tile 1.
    run_job("three", 3, 1, 5, 0, 1'b0);

    // Zero-tile job.
    d0 = done_cnt;
    do_start(0);
    check("zero done pulse", done, 1'b1);
    check("zero busy", busy, 1'b0);
    tick();
    check("zero done ends", done, 1'b0);
    check("zero busy later", busy, 1'b0);
    tick();
    check("zero done count", 128'(done_cnt - d0), 128'd1);

    // Start while busy, with a 10-cycle activation delay.
    run_job("restart-ignored", 1, -1, 0, 10, 1'b1);

    // Reset during OUTPUT, then a clean job.
    d0 = done_cnt;
    expect_job(1);
    do_start(1);
    send_act(0, 0, 1'b0);
    wait_res();
    aresetn = 1'b0;
    #1;
    check("reset mid-output res_valid", res_valid, 1'b0);
    check("reset mid-output busy", busy, 1'b0);
    check("reset mid-output res", {res_data, res_tile}, 0);
    check("reset mid-output weights", core_w_val, 0);
    exp_addr.delete();
    exp_tile.delete();
    tick();
    tick();
    aresetn = 1'b1;
    tick();
    tick();
    check("post-reset idle", busy, 1'b0);
    check("post-reset no done", 128'(done_cnt - d0), 128'd0);
    run_job("post-reset", 2, -1, 0, 0, 1'b0);

    // Abort during cycle 4 of COMPUTE on the long-latency instance.
    start8 = 1'b1;
    tick();
    start8 = 1'b0;
    cyc = 0;
    while (!core_en8 && cyc < 50) begin tick(); cyc++; end
    check("abort: reached compute", core_en8, 1'b1);
    tick();
    tick();
    tick();
    check("abort: core_en in cycle 4", core_en8, 1'b1);
    abort8 = 1'b1;
    tick();
    abort8 = 1'b0;
    check("abort: idle next cycle", busy8, 1'b0);
    check("abort: core_en off", core_en8, 1'b0);
    check("abort: no res_valid", res_valid8, 1'b0);
    check("abort: no done", done8, 1'b0);
    n_rv = 0;
    n_dn = 0;
    repeat (12) begin
      tick();
      n_rv += int'(res_valid8);
      n_dn += int'(done8);
    end
    check("abort: res_valid never", 128'(n_rv), 128'd0);
    check("abort: done never", 128'(n_dn), 128'd0);
    check("abort: stays idle", busy8, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
